// File: rtl/demux1x2_8bits.sv
`default_nettype none
// ============================================================================
//  Module      : demux1x2_8bits
//  Description : RX 1:2 lane splitter. Routes even byte slots to lane 0 and
//                odd byte slots to lane 1 through one registered stage.
//                Optional comma alignment is built when COM_ALIGN_EN is
//                defined; the default build has no alignment FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module demux1x2_8bits #(
   parameter logic [7:0] COM_SYMBOL = 8'hBC
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic [7:0] data_out0,
   output logic       valid_out0,
   output logic [7:0] data_out1,
   output logic       valid_out1,
   output logic       aligned,
   output logic       align_err
);

   logic       phase_q, phase_d;
   logic [7:0] data0_q, data0_d;
   logic [7:0] data1_q, data1_d;
   logic       valid0_q, valid0_d;
   logic       valid1_q, valid1_d;
   logic       align_err_q, align_err_d;

`ifdef COM_ALIGN_EN
   typedef enum logic [0:0] {
      SEARCH  = 1'b0,
      ALIGNED = 1'b1
   } state_t;

   state_t state_q, state_d;
   logic   com_hit;

   // A comma only counts when it arrives as a valid byte.
   assign com_hit = valid_in && (data_in == COM_SYMBOL);

   // Next-state, slot routing and comma handling.
   always_comb begin
      phase_d     = ~phase_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      valid0_d    = 1'b0;
      valid1_d    = 1'b0;
      align_err_d = 1'b0;
      state_d     = state_q;
      if (state_q == SEARCH) begin
         // Everything but a comma is dropped while searching.
         if (com_hit) begin
            data0_d  = data_in;
            valid0_d = 1'b1;
            phase_d  = 1'b1;
            state_d  = ALIGNED;
         end
      end else begin
         if (com_hit) begin
            // Comma always lands on lane 0; a lane-1 comma re-locks phase.
            data0_d     = data_in;
            valid0_d    = 1'b1;
            phase_d     = 1'b1;
            align_err_d = phase_q;
         end else if (valid_in) begin
            if (phase_q) begin
               data1_d  = data_in;
               valid1_d = 1'b1;
            end else begin
               data0_d  = data_in;
               valid0_d = 1'b1;
            end
         end
      end
   end

   // Alignment state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= SEARCH;
      end else begin
         state_q <= state_d;
      end
   end

   assign aligned = (state_q == ALIGNED);
`else
   logic aligned_q, aligned_d;
   logic unused_com_symbol;

   // Comma value is irrelevant without the alignment FSM.
   assign unused_com_symbol = ^COM_SYMBOL;

   // Free-running slot routing; nothing is ever dropped.
   always_comb begin
      phase_d     = ~phase_q;
      data0_d     = data0_q;
      data1_d     = data1_q;
      valid0_d    = 1'b0;
      valid1_d    = 1'b0;
      align_err_d = 1'b0;
      aligned_d   = 1'b1;
      if (valid_in) begin
         if (phase_q) begin
            data1_d  = data_in;
            valid1_d = 1'b1;
         end else begin
            data0_d  = data_in;
            valid0_d = 1'b1;
         end
      end
   end

   // Lane phase is considered locked from the first edge out of reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         aligned_q <= 1'b0;
      end else begin
         aligned_q <= aligned_d;
      end
   end

   assign aligned = aligned_q;
`endif

   // Phase and per-lane output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q     <= 1'b0;
         data0_q     <= 8'h00;
         data1_q     <= 8'h00;
         valid0_q    <= 1'b0;
         valid1_q    <= 1'b0;
         align_err_q <= 1'b0;
      end else begin
         phase_q     <= phase_d;
         data0_q     <= data0_d;
         data1_q     <= data1_d;
         valid0_q    <= valid0_d;
         valid1_q    <= valid1_d;
         align_err_q <= align_err_d;
      end
   end

   assign data_out0  = data0_q;
   assign data_out1  = data1_q;
   assign valid_out0 = valid0_q;
   assign valid_out1 = valid1_q;
   assign align_err  = align_err_q;

endmodule
`default_nettype wire
